// File: rtl/edge_event_capture.sv
// Multi-channel edge detector with sticky, write-1-to-clear pending flags and an irq output.
// Define EDGE_DEBOUNCE_EN to insert a per-channel debounce filter ahead of edge detection.
module edge_event_capture #(
    parameter int unsigned DATAWIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] i,
    input  logic [DATAWIDTH-1:0] rise_en,
    input  logic [DATAWIDTH-1:0] fall_en,
    input  logic [DATAWIDTH-1:0] clr,
    output logic [DATAWIDTH-1:0] o,
    output logic [DATAWIDTH-1:0] pending,
    output logic                 irq
);

    if (SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_param_check
        $error("edge_event_capture: SYNC_STAGES must be >= 2 and FILT_CYCLES >= 1");
    end

    logic [DATAWIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATAWIDTH-1:0] sync_out;
    logic [DATAWIDTH-1:0] lvl;
    logic [DATAWIDTH-1:0] old_q;
    logic [DATAWIDTH-1:0] o_q;
    logic [DATAWIDTH-1:0] pending_q;
    logic [DATAWIDTH-1:0] pending_d;
    logic [DATAWIDTH-1:0] rise;
    logic [DATAWIDTH-1:0] fall;
    logic                 irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(FILT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

    logic [CntW-1:0]      cnt_q [DATAWIDTH];
    logic [DATAWIDTH-1:0] lvl_q;

    // lvl follows sync_out only after FILT_CYCLES consecutive clks of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q <= '0;
            for (int n = 0; n < DATAWIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < DATAWIDTH; n++) begin
                if (sync_out[n] == lvl_q[n]) begin
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] == CntMax) begin
                    lvl_q[n] <= sync_out[n];
                    cnt_q[n] <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + 1'b1;
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync_out;
`endif

    always_comb begin
        rise      = lvl & ~old_q & rise_en;
        fall      = ~lvl & old_q & fall_en;
        // A new pulse overrides a simultaneous clear.
        pending_d = o_q | (pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_q     <= '0;
            o_q       <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            old_q     <= lvl;
            o_q       <= rise | fall;
            pending_q <= pending_d;
            irq_q     <= |pending_d;
        end
    end

    assign o       = o_q;
    assign pending = pending_q;
    assign irq     = irq_q;

endmodule
